// File: rtl/bus_master_seq.sv
// Bus initiator: host commands queue in a small FIFO and are issued one at a time on the master port.
// Define BUS_MASTER_SEQ_TIMEOUT_EN to build the grant-timeout abort (wait counter + rsp_err).
module bus_master_seq #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        M_req,
  output logic        M_wr,
  output logic [7:0]  M_addr,
  output logic [31:0] M_dout,
  input  logic        M_grant,
  input  logic [31:0] M_din
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bus_master_seq: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("bus_master_seq: TIMEOUT_CYC must be in 1..255");
  end

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, fifo_empty;

  assign fifo_empty = (count == '0);
  // Ready depends only on the registered count, so a full FIFO refuses a push
  // even in the cycle it pops.
  assign cmd_ready  = (count != CNT_W'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, and leaving it unreset lets it map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
  end

  // ---------------------------------------------------------------------------
  // Grant timeout
  // ---------------------------------------------------------------------------
  logic timeout_hit;

`ifdef BUS_MASTER_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;

  // Abort on the ungranted cycle that brings the counter to TIMEOUT_CYC.
  assign timeout_hit = (state == REQ) && !M_grant && (wait_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (pop) begin
        wait_cnt <= '0;
        err_q    <= 1'b0;
      end else begin
        if (state == REQ && !M_grant && wait_cnt != 8'(TIMEOUT_CYC))
          wait_cnt <= wait_cnt + 8'd1;
        if (timeout_hit)
          err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Working registers and read-data capture
  // ---------------------------------------------------------------------------
  cmd_t        work;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      work    <= '0;
      rdata_q <= '0;
    end else begin
      if (pop) begin
        work    <= fifo_mem[rd_ptr];
        rdata_q <= '0;
      end else if (state == RD) begin
        rdata_q <= M_din;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign busy      = !fifo_empty || (state != IDLE);

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: if (!fifo_empty) state_next = REQ;
      REQ: begin
        if (M_grant)          state_next = work.wr ? RSP : RD;
        else if (timeout_hit) state_next = RSP;
      end
      RD:      state_next = RSP;
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    M_req     = 1'b0;
    M_wr      = 1'b0;
    M_addr    = '0;
    M_dout    = '0;
    rsp_valid = 1'b0;
    case (state)
      REQ: begin
        M_req  = 1'b1;
        M_wr   = work.wr;
        M_addr = work.addr;
        M_dout = work.wdata;
      end
      RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_master_seq.sv
// Self-checking bench for bus_master_seq: scenario tasks plus a response scoreboard.
// Honours BUS_MASTER_SEQ_TIMEOUT_EN the same way the design does.
module tb_bus_master_seq;

  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        M_req;
  logic        M_wr;
  logic [7:0]  M_addr;
  logic [31:0] M_dout;
  logic        M_grant = 1'b0;
  logic [31:0] M_din = '0;

  bus_master_seq #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .M_req     (M_req),
    .M_wr      (M_wr),
    .M_addr    (M_addr),
    .M_dout    (M_dout),
    .M_grant   (M_grant),
    .M_din     (M_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] seen_addr[$];
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  // Scoreboard: every completion pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected got err=%0b rdata=%h, want no response", rsp_err, rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== {mon_e.err, mon_e.rdata})
          $display("FAIL rsp_data got err=%0b rdata=%h, want err=%0b rdata=%h",
                   rsp_err, rsp_rdata, mon_e.err, mon_e.rdata);
        else
          pass_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one command for one cycle; the expectation is queued only when a response is due.
  task automatic push(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input bit expect_rsp, input logic [31:0] exp_rdata, input logic exp_err);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    if (expect_rsp) exp_q.push_back(exp_t'{exp_rdata, exp_err});
    tick();
    cmd_valid = 1'b0;
  endtask

  // Run until idle, logging granted addresses; an expired budget counts as a failure.
  task automatic drain(input int max_cyc, input string tag);
    int n = 0;
    while (busy === 1'b1 && n < max_cyc) begin
      if (M_req === 1'b1 && M_grant === 1'b1) seen_addr.push_back(M_addr);
      tick();
      n++;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_drain busy=%b after %0d cycles, want 0", tag, busy, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({cmd_ready, rsp_valid, busy, M_req, M_wr, rsp_err} !== 6'b100000)
      $display("FAIL reset_ctl got %b, want 100000",
               {cmd_ready, rsp_valid, busy, M_req, M_wr, rsp_err});
    else pass_cnt++;
    total_cnt++;
    if ({rsp_rdata, M_addr, M_dout} !== 72'h0)
      $display("FAIL reset_data got rdata=%h addr=%h dout=%h, want all 0", rsp_rdata, M_addr, M_dout);
    else pass_cnt++;
  endtask

  task automatic test_single_write();
    M_grant = 1'b1;
    push(1'b1, 8'h05, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    total_cnt++;   // cycle 1: popping
    if ({M_req, busy} !== 2'b01) $display("FAIL wr_c1 got req,busy=%b, want 01", {M_req, busy});
    else pass_cnt++;
    tick();        // cycle 2: REQ
    total_cnt++;
    if ({M_req, M_wr, M_addr, M_dout} !== {1'b1, 1'b1, 8'h05, 32'hDEADBEEF})
      $display("FAIL wr_req got req=%b wr=%b addr=%h dout=%h, want 1 1 05 deadbeef",
               M_req, M_wr, M_addr, M_dout);
    else pass_cnt++;
    tick();        // cycle 3: RSP
    total_cnt++;
    if ({rsp_valid, M_req, M_addr, M_dout} !== {1'b1, 1'b0, 8'h0, 32'h0})
      $display("FAIL wr_rsp got valid=%b req=%b addr=%h dout=%h, want 1 0 00 0",
               rsp_valid, M_req, M_addr, M_dout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({rsp_valid, busy} !== 2'b00) $display("FAIL wr_done got valid,busy=%b, want 00", {rsp_valid, busy});
    else pass_cnt++;
  endtask

  task automatic test_read_stall();
    int req_cycles = 0;
    M_grant = 1'b0;
    M_din   = 32'hBAD0BAD0;
    push(1'b0, 8'h05, 32'h0, 1'b1, 32'h12345678, 1'b0);
    tick();        // cycle 2: first REQ
    for (int i = 0; i < 3; i++) begin
      if (M_req === 1'b1) req_cycles++;
      tick();
    end
    M_grant = 1'b1; // cycle 5: granted
    if (M_req === 1'b1) req_cycles++;
    total_cnt++;
    if ({M_wr, M_addr} !== {1'b0, 8'h05})
      $display("FAIL rd_req got wr=%b addr=%h, want 0 05", M_wr, M_addr);
    else pass_cnt++;
    tick();        // cycle 6: RD
    M_grant = 1'b0;
    M_din   = 32'h12345678;
    total_cnt++;
    if ({M_req, rsp_valid} !== 2'b00) $display("FAIL rd_phase got req,valid=%b, want 00", {M_req, rsp_valid});
    else pass_cnt++;
    tick();        // cycle 7: RSP
    M_din = 32'hBAD0BAD0;
    total_cnt++;
    if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_time got valid=%b, want 1", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (req_cycles != 4) $display("FAIL rd_req_len got %0d cycles, want 4", req_cycles);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_fifo_full();
    logic [7:0] want_addr[$];
    bit ready_ok = 1'b1;
    seen_addr.delete();
    M_grant = 1'b0;
    M_din   = 32'hCAFEF00D;
    push(1'b1, 8'h10, 32'h00001000, 1'b1, 32'h0, 1'b0);
    want_addr.push_back(8'h10);
    for (int i = 0; i < 4; i++) begin
      if (cmd_ready !== 1'b1) ready_ok = 1'b0;
      if (i == 2) push(1'b0, 8'h11 + 8'(i), 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);
      else        push(1'b1, 8'h11 + 8'(i), 32'h1100 + 32'(i), 1'b1, 32'h0, 1'b0);
      want_addr.push_back(8'h11 + 8'(i));
    end
    total_cnt++;
    if (!ready_ok) $display("FAIL fifo_ready_fill cmd_ready dropped early, want 1 for 4 pushes");
    else pass_cnt++;
    total_cnt++;
    if (cmd_ready !== 1'b0) $display("FAIL fifo_full got cmd_ready=%b, want 0", cmd_ready);
    else pass_cnt++;
    push(1'b1, 8'h99, 32'h99999999, 1'b0, 32'h0, 1'b0);   // refused
    total_cnt++;
    if ({cmd_ready, busy} !== 2'b01) $display("FAIL fifo_refuse got ready,busy=%b, want 01", {cmd_ready, busy});
    else pass_cnt++;
    M_grant = 1'b1;
    drain(80, "fifo");
    total_cnt++;
    if (seen_addr != want_addr)
      $display("FAIL fifo_order got %0d transfers first=%h last=%h, want 5 in push order 10..14",
               seen_addr.size(), seen_addr.size() ? seen_addr[0] : 8'h0,
               seen_addr.size() ? seen_addr[$] : 8'h0);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int n = 0;
    M_grant = 1'b0;
    M_din   = 32'hFFFFFFFF;
`ifdef BUS_MASTER_SEQ_TIMEOUT_EN
    seen_addr.delete();
    push(1'b0, 8'h33, 32'h0, 1'b1, 32'h0, 1'b1);
    push(1'b1, 8'h44, 32'h00004444, 1'b1, 32'h0, 1'b0);
    while (M_req === 1'b1 && n < 40) begin
      req_cycles++;
      tick();
      n++;
    end
    total_cnt++;
    if (req_cycles != TIMEOUT_CYC) $display("FAIL to_req_len got %0d cycles, want %0d", req_cycles, TIMEOUT_CYC);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b1) $display("FAIL to_rsp_time got valid=%b, want 1", rsp_valid);
    else pass_cnt++;
    M_grant = 1'b1;
    drain(20, "to");
    total_cnt++;
    if (seen_addr.size() != 1 || seen_addr[0] !== 8'h44)
      $display("FAIL to_next got %0d transfers, want 1 at addr 44", seen_addr.size());
    else pass_cnt++;
`else
    push(1'b0, 8'h33, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 40; i++) begin
      if (M_req === 1'b1) req_cycles++;
      tick();
    end
    total_cnt++;
    if (req_cycles != 40) $display("FAIL nto_req_hold got %0d of 40 cycles, want 40", req_cycles);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({busy, M_req} !== 2'b00) $display("FAIL nto_recover got busy,req=%b, want 00", {busy, M_req});
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    M_grant = 1'b0;
    push(1'b1, 8'hA0, 32'hA0A0A0A0, 1'b0, 32'h0, 1'b0);
    push(1'b0, 8'hA1, 32'h0, 1'b0, 32'h0, 1'b0);
    push(1'b1, 8'hA2, 32'hA2A2A2A2, 1'b0, 32'h0, 1'b0);
    total_cnt++;
    if ({M_req, busy} !== 2'b11) $display("FAIL rst_mid_pre got req,busy=%b, want 11", {M_req, busy});
    else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++;
    if ({M_req, busy, cmd_ready} !== 3'b001)
      $display("FAIL rst_mid got req,busy,ready=%b, want 001", {M_req, busy, cmd_ready});
    else pass_cnt++;
    reset   = 1'b0;
    M_grant = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid === 1'b1 || M_req === 1'b1) stray++;
      tick();
    end
    total_cnt++;
    if (stray != 0) $display("FAIL rst_flush got %0d active cycles, want 0", stray);
    else pass_cnt++;
  endtask

  initial begin
    tick();
    test_reset();
    test_single_write();
    test_read_stall();
    test_fifo_full();
    test_timeout();
    test_reset_mid();
    repeat (2) tick();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL rsp_missing got %0d outstanding, want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
